// File: rtl/pwm_csr_pkg.sv
// Shared definitions for the PWM_CSR bus initiator: register map, ctrl mask,
// FSM state encoding, bus operation codes and the ctrl readback compare.
package pwm_csr_pkg;

  localparam logic [15:0] ADDR_CTRL       = 16'd0;
  localparam logic [15:0] ADDR_DIVISOR    = 16'd2;
  localparam logic [15:0] ADDR_PERIOD     = 16'd4;
  localparam logic [15:0] ADDR_DUTY_CYCLE = 16'd6;
  localparam logic [7:0]  CTRL_MASK       = 8'hDF;

  localparam int unsigned NumWrites = 4;
  localparam int unsigned NumReads  = 4;

  typedef enum logic [3:0] {
    StIdle,
    StWDiv,
    StWPer,
    StWDuty,
    StWCtrl,
    StRDiv,
    StRPer,
    StRDuty,
    StRCtrl,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpWrite,
    OpRead
  } bus_op_e;

  // Bit 5 of ctrl is not stored by the slave, so it is excluded from the check.
  function automatic logic ctrl_match(input logic [15:0] rd, input logic [7:0] exp);
    return (rd[15:8] == 8'h00) && ((rd[7:0] & CTRL_MASK) == (exp & CTRL_MASK));
  endfunction

endpackage

// File: rtl/pwm_csr_bus_drv.sv
// Registered bus driver: turns {op, addr, data} into one-cycle strobes and
// checks readdata during read cycles. Readback logic exists only with PWM_CSR_READBACK_EN.
module pwm_csr_bus_drv
  import pwm_csr_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  bus_op_e     i_op,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  input  logic        i_is_ctrl,
  input  logic [15:0] i_readdata,
  output logic        o_chipselect,
  output logic        o_write_enable,
  output logic        o_read_enable,
  output logic [15:0] o_address,
  output logic [15:0] o_writedata,
  output logic        o_mismatch
);

  logic        r_cs;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_cs    <= (i_op != OpNone);
      r_we    <= (i_op == OpWrite);
      r_addr  <= (i_op != OpNone) ? i_addr : '0;
      r_wdata <= (i_op == OpWrite) ? i_data : '0;
    end
  end

  assign o_chipselect   = r_cs;
  assign o_write_enable = r_we;
  assign o_address      = r_addr;
  assign o_writedata    = r_wdata;

`ifdef PWM_CSR_READBACK_EN
  logic        r_re;
  logic [15:0] r_exp;
  logic        r_is_ctrl;
  logic        w_match;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_re      <= 1'b0;
      r_exp     <= '0;
      r_is_ctrl <= 1'b0;
    end else begin
      r_re      <= (i_op == OpRead);
      r_exp     <= (i_op == OpRead) ? i_data : '0;
      r_is_ctrl <= (i_op == OpRead) && i_is_ctrl;
    end
  end

  // readdata is combinational from the slave, so compare in the read cycle itself.
  assign w_match       = r_is_ctrl ? ctrl_match(i_readdata, r_exp[7:0]) : (i_readdata == r_exp);
  assign o_read_enable = r_re;
  assign o_mismatch    = r_re && !w_match;
`else
  logic w_unused_rb;
  assign w_unused_rb   = ^{i_readdata, i_is_ctrl};
  assign o_read_enable = 1'b0;
  assign o_mismatch    = 1'b0;
`endif

endmodule

// File: rtl/pwm_csr_master.sv
// PWM_CSR bus initiator: accepts a configuration and writes div, period, duty, ctrl.
// Optional readback and compare of all four registers under PWM_CSR_READBACK_EN.
module pwm_csr_master
  import pwm_csr_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [7:0]  i_cfg_ctrl,
  input  logic [15:0] i_cfg_divisor,
  input  logic [15:0] i_cfg_period,
  input  logic [15:0] i_cfg_duty,
  output logic        o_done,
  output logic        o_err,
  output logic        o_chipselect,
  output logic        o_write_enable,
  output logic        o_read_enable,
  output logic [15:0] o_address,
  output logic [15:0] o_writedata,
  input  logic [15:0] i_readdata
);

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_ctrl;
  logic [15:0] r_divisor;
  logic [15:0] r_period;
  logic [15:0] r_duty;
  logic        r_mismatch;
  logic        r_err;

  bus_op_e     w_op;
  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic        w_is_ctrl;
  logic        w_accept;
  logic        w_reject;
  logic        w_mismatch;

  // Bus outputs are registered, so each state issues the access of the state it moves to.
  always_comb begin
    w_state_d = r_state;
    w_op      = OpNone;
    w_addr    = '0;
    w_data    = '0;
    w_is_ctrl = 1'b0;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cfg_valid) begin
          w_accept = 1'b1;
          if (i_cfg_duty > i_cfg_period) begin
            w_reject  = 1'b1;
            w_state_d = StDone;
          end else begin
            w_state_d = StWDiv;
            w_op      = OpWrite;
            w_addr    = ADDR_DIVISOR;
            w_data    = i_cfg_divisor;
          end
        end
      end
      StWDiv: begin
        w_state_d = StWPer;
        w_op      = OpWrite;
        w_addr    = ADDR_PERIOD;
        w_data    = r_period;
      end
      StWPer: begin
        w_state_d = StWDuty;
        w_op      = OpWrite;
        w_addr    = ADDR_DUTY_CYCLE;
        w_data    = r_duty;
      end
      StWDuty: begin
        w_state_d = StWCtrl;
        w_op      = OpWrite;
        w_addr    = ADDR_CTRL;
        w_data    = {8'h00, r_ctrl};
      end
`ifdef PWM_CSR_READBACK_EN
      StWCtrl: begin
        w_state_d = StRDiv;
        w_op      = OpRead;
        w_addr    = ADDR_DIVISOR;
        w_data    = r_divisor;
      end
      StRDiv: begin
        w_state_d = StRPer;
        w_op      = OpRead;
        w_addr    = ADDR_PERIOD;
        w_data    = r_period;
      end
      StRPer: begin
        w_state_d = StRDuty;
        w_op      = OpRead;
        w_addr    = ADDR_DUTY_CYCLE;
        w_data    = r_duty;
      end
      StRDuty: begin
        w_state_d = StRCtrl;
        w_op      = OpRead;
        w_addr    = ADDR_CTRL;
        w_data    = {8'h00, r_ctrl};
        w_is_ctrl = 1'b1;
      end
      StRCtrl: w_state_d = StDone;
`else
      StWCtrl: w_state_d = StDone;
`endif
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_ctrl     <= '0;
      r_divisor  <= '0;
      r_period   <= '0;
      r_duty     <= '0;
      r_mismatch <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_ctrl     <= i_cfg_ctrl;
        r_divisor  <= i_cfg_divisor;
        r_period   <= i_cfg_period;
        r_duty     <= i_cfg_duty;
        r_mismatch <= 1'b0;
        r_err      <= w_reject;
      end else begin
        if (w_mismatch) begin
          r_mismatch <= 1'b1;
        end
        // Include the final read's compare, which is only visible in this cycle.
        if (w_state_d == StDone) begin
          r_err <= r_mismatch | w_mismatch;
        end
      end
    end
  end

`ifndef PWM_CSR_READBACK_EN
  logic w_unused_divisor;
  assign w_unused_divisor = ^r_divisor;
`endif

  pwm_csr_bus_drv u_bus_drv (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_op           (w_op),
    .i_addr         (w_addr),
    .i_data         (w_data),
    .i_is_ctrl      (w_is_ctrl),
    .i_readdata     (i_readdata),
    .o_chipselect   (o_chipselect),
    .o_write_enable (o_write_enable),
    .o_read_enable  (o_read_enable),
    .o_address      (o_address),
    .o_writedata    (o_writedata),
    .o_mismatch     (w_mismatch)
  );

  assign o_cfg_ready = (r_state == StIdle);
  assign o_done      = (r_state == StDone);
  assign o_err       = r_err;

endmodule

// File: tb/tb_pwm_csr_master.sv
// Directed bench for pwm_csr_master with a small PWM register slave model;
// readback cases are exercised when PWM_CSR_READBACK_EN is defined.
module tb_pwm_csr_master;

`ifdef PWM_CSR_READBACK_EN
  localparam bit RB     = 1'b1;
  localparam int DoneK  = 9;
  localparam int AccGap = 10;
`else
  localparam bit RB     = 1'b0;
  localparam int DoneK  = 5;
  localparam int AccGap = 6;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_ctrl;
  logic [15:0] cfg_divisor;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic        done;
  logic        err;
  logic        cs;
  logic        we;
  logic        re;
  logic [15:0] address;
  logic [15:0] wdata;
  logic [15:0] readdata;

  int  n_tests = 0;
  int  n_fail  = 0;
  time t_acc   = 0;
  time t_prev  = 0;

  logic [15:0] slv_regs [4];
  logic        corrupt_en  = 1'b0;
  logic [15:0] corrupt_adr = 16'd0;
  logic [15:0] corrupt_val = 16'd0;

  always #5 clk = ~clk;

  pwm_csr_master dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_ctrl     (cfg_ctrl),
    .i_cfg_divisor  (cfg_divisor),
    .i_cfg_period   (cfg_period),
    .i_cfg_duty     (cfg_duty),
    .o_done         (done),
    .o_err          (err),
    .o_chipselect   (cs),
    .o_write_enable (we),
    .o_read_enable  (re),
    .o_address      (address),
    .o_writedata    (wdata),
    .i_readdata     (readdata)
  );

  // Slave model: ctrl keeps only the implemented bits.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) slv_regs[i] <= 16'h0000;
    end else if (cs && we) begin
      if (address == 16'd0) slv_regs[0] <= {8'h00, wdata[7:0] & 8'hDF};
      else                  slv_regs[address[2:1]] <= wdata;
    end
  end

  always_comb begin
    readdata = slv_regs[address[2:1]];
    if (corrupt_en && address == corrupt_adr) readdata = corrupt_val;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected {cs, we, re, address, writedata} in cycle k after accept.
  function automatic logic [34:0] exp_bus(input int k, input logic [7:0] c,
                                          input logic [15:0] d, input logic [15:0] p,
                                          input logic [15:0] u);
    logic [15:0] a;
    logic [15:0] w;
    case ((k - 1) % 4)
      0:       begin a = 16'd2; w = d; end
      1:       begin a = 16'd4; w = p; end
      2:       begin a = 16'd6; w = u; end
      default: begin a = 16'd0; w = {8'h00, c}; end
    endcase
    if (k >= 1 && k <= 4) return {1'b1, 1'b1, 1'b0, a, w};
    if (RB && k >= 5 && k <= 8) return {1'b1, 1'b0, 1'b1, a, 16'h0000};
    return 35'd0;
  endfunction

  // Called at a negedge; issues one request and checks every cycle until ready returns.
  task automatic do_seq(input logic [7:0] c, input logic [15:0] d, input logic [15:0] p,
                        input logic [15:0] u, input logic exp_err, input int rst_at,
                        input bit hold, input logic [7:0] nc, input logic [15:0] nd,
                        input logic [15:0] np, input logic [15:0] nu);
    int waited = 0;
    int last;
    while (!cfg_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) begin
      check("ready_wait", {63'd0, cfg_ready}, 64'd1);
      return;
    end
    cfg_ctrl = c; cfg_divisor = d; cfg_period = p; cfg_duty = u; cfg_valid = 1'b1;
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = $time;
    last   = (u > p) ? 1 : DoneK;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k < last) begin
        check($sformatf("bus_c%0d", k), {29'd0, cs, we, re, address, wdata},
              {29'd0, exp_bus(k, c, d, p, u)});
        check($sformatf("busy_c%0d", k), {61'd0, cfg_ready, done, err}, 64'd0);
      end else if (k == last) begin
        check("done_bus", {29'd0, cs, we, re, address, wdata}, 64'd0);
        check("done_flags", {61'd0, cfg_ready, done, err}, {61'd0, 1'b0, 1'b1, exp_err});
      end else begin
        check("ready_back", {61'd0, cfg_ready, done, cs}, {61'd0, 1'b1, 1'b0, 1'b0});
      end
      if (k == 1) begin
        if (hold) begin
          cfg_ctrl = nc; cfg_divisor = nd; cfg_period = np; cfg_duty = nu;
        end else begin
          cfg_valid = 1'b0;
          cfg_ctrl = 8'hA5; cfg_divisor = 16'hBEEF; cfg_period = 16'hCAFE; cfg_duty = 16'h1234;
        end
      end
      if (k == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_bus", {29'd0, cs, we, re, address, wdata}, 64'd0);
        check("rst_flags", {62'd0, cfg_ready, done}, {62'd0, 1'b1, 1'b0});
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", {62'd0, cfg_ready, done}, {62'd0, 1'b1, 1'b0});
        end
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0;
    cfg_ctrl = '0; cfg_divisor = '0; cfg_period = '0; cfg_duty = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", {61'd0, cfg_ready, done, err}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("reset_bus", {29'd0, cs, we, re, address, wdata}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_seq(8'h01, 16'd10, 16'd100, 16'd25, 1'b0, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    check("slv_div",  {48'd0, slv_regs[1]}, 64'd10);
    check("slv_per",  {48'd0, slv_regs[2]}, 64'd100);
    check("slv_duty", {48'd0, slv_regs[3]}, 64'd25);
    check("slv_ctrl", {48'd0, slv_regs[0]}, 64'h0001);

    do_seq(8'hFF, 16'd10, 16'd100, 16'd25, 1'b0, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    check("slv_ctrl_ff", {48'd0, slv_regs[0]}, 64'h00DF);

`ifdef PWM_CSR_READBACK_EN
    corrupt_en = 1'b1; corrupt_adr = 16'd4; corrupt_val = 16'd99;
    do_seq(8'h01, 16'd10, 16'd100, 16'd25, 1'b1, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    corrupt_en = 1'b0;
`endif

    do_seq(8'h01, 16'd10, 16'd100, 16'd200, 1'b1, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    do_seq(8'h01, 16'd10, 16'd100, 16'd100, 1'b0, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);

    do_seq(8'h01, 16'd10, 16'd100, 16'd25, 1'b0, 2, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    do_seq(8'h03, 16'd20, 16'd50, 16'd10, 1'b0, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);

    do_seq(8'h11, 16'd7, 16'd80, 16'd40, 1'b0, 0, 1'b1, 8'h12, 16'd9, 16'd90, 16'd30);
    do_seq(8'h12, 16'd9, 16'd90, 16'd30, 1'b0, 0, 1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
    check("accept_gap", (t_acc - t_prev) / 10, AccGap);
    check("slv_per_b2b", {48'd0, slv_regs[2]}, 64'd90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
